// File: rtl/mwave_timer_ctrl.sv
// rtl/mwave_timer_ctrl.sv - microwave M:SS countdown sequencer; optional auto-ending beep with MWAVE_BEEP_EN
module mwave_timer_ctrl
`ifdef MWAVE_BEEP_EN
#(
    parameter int BEEP_TICKS = 3
)
`endif
(
    input  logic       clock,
    input  logic       clear,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       heating,
    output logic       done,
    output logic [2:0] state
`ifdef MWAVE_BEEP_EN
    ,
    output logic       beep
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mins_q, mins_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       heating_q, heating_d;
    logic       done_q, done_d;

    logic [3:0] dec_mins, dec_tens, dec_ones;
    logic       dec_zero;
    logic       time_zero;
    logic       key_ok;

`ifdef MWAVE_BEEP_EN
    localparam logic [7:0] BEEP_LAST = 8'(BEEP_TICKS - 1);
    logic       beep_q, beep_d;
    logic [7:0] beep_cnt_q, beep_cnt_d;
`endif

    assign time_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign key_ok    = key_valid && (key_digit <= 4'd9);

    // One-second decrement with the ones -> tens -> minutes borrow cascade
    always_comb begin
        dec_ones = ones_q - 4'd1;
        dec_tens = tens_q;
        dec_mins = mins_q;
        if (ones_q == 4'd0) begin
            dec_ones = 4'd9;
            if (tens_q == 4'd0) begin
                dec_tens = 4'd5;
                dec_mins = mins_q - 4'd1;
            end else begin
                dec_tens = tens_q - 4'd1;
            end
        end
        dec_zero = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

    // Next-state and digit update; branch order encodes stop > start > tick > key
    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
`ifdef MWAVE_BEEP_EN
        beep_cnt_d = beep_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (stop) begin
                    state_d = S_IDLE;
                    mins_d  = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else if (start && door_closed && !time_zero) begin
                    state_d = S_RUN;
                end else if (key_ok) begin
                    state_d = S_ENTRY;
                    mins_d  = tens_q;
                    tens_d  = ones_q;
                    ones_d  = key_digit;
                end
            end
            S_RUN: begin
                if (!door_closed || stop) begin
                    state_d = S_PAUSE;
                end else if (tick_1hz) begin
                    mins_d = dec_mins;
                    tens_d = dec_tens;
                    ones_d = dec_ones;
                    if (dec_zero) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    mins_d  = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else if (start && door_closed) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (!door_closed || stop) begin
                    state_d = S_IDLE;
`ifdef MWAVE_BEEP_EN
                end else if (tick_1hz) begin
                    if (beep_cnt_q == BEEP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        beep_cnt_d = beep_cnt_q + 8'd1;
                    end
`endif
                end else if (key_ok) begin
                    state_d = S_ENTRY;
                    mins_d  = tens_q;
                    tens_d  = ones_q;
                    ones_d  = key_digit;
                end
            end
            default: begin
                state_d = S_IDLE;
                mins_d  = 4'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end
        endcase
`ifdef MWAVE_BEEP_EN
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            beep_cnt_d = 8'd0;
        end
        beep_d = (state_d == S_DONE);
`endif
        heating_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // State, digit and output registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            mins_q    <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            heating_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MWAVE_BEEP_EN
            beep_q     <= 1'b0;
            beep_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            mins_q    <= mins_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            heating_q <= heating_d;
            done_q    <= done_d;
`ifdef MWAVE_BEEP_EN
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
`endif
        end
    end

    assign mins     = mins_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign heating  = heating_q;
    assign done     = done_q;
    assign state    = state_q;
`ifdef MWAVE_BEEP_EN
    assign beep     = beep_q;
`endif

endmodule

// File: tb/tb_mwave_timer_ctrl.sv
// tb/tb_mwave_timer_ctrl.sv - directed self-checking bench for mwave_timer_ctrl
module tb_mwave_timer_ctrl;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] mins, sec_tens, sec_ones;
    logic       heating, done;
    logic [2:0] state;
`ifdef MWAVE_BEEP_EN
    logic       beep;
`endif

    int total  = 0;
    int passed = 0;

    mwave_timer_ctrl dut (
        .clock       (clock),
        .clear       (clear),
        .tick_1hz    (tick_1hz),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .heating     (heating),
        .done        (done),
        .state       (state)
`ifdef MWAVE_BEEP_EN
        ,
        .beep        (beep)
`endif
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] tm();
        return {mins, sec_tens, sec_ones};
    endfunction

    function automatic logic [11:0] st();
        return {9'd0, state};
    endfunction

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
            cyc();
        end
    endtask

    initial begin
        // reset state
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("rst_state", st(), 12'd0);
        check("rst_time", tm(), 12'h000);
        check("rst_heat", {11'd0, heating}, 12'd0);
        check("rst_done", {11'd0, done}, 12'd0);

        // 1:30 entry and full countdown
        press(4'd1); press(4'd3); press(4'd0);
        check("entry_130", tm(), 12'h130);
        check("entry_state", st(), 12'd1);
        do_start();
        check("run_state", st(), 12'd2);
        check("run_heat", {11'd0, heating}, 12'd1);
        ticks(1);
        check("tick_129", tm(), 12'h129);
        ticks(88);
        check("tick_001", tm(), 12'h001);
        check("still_run", st(), 12'd2);
        ticks(1);
        check("end_time", tm(), 12'h000);
        check("end_state", st(), 12'd4);
        check("end_done", {11'd0, done}, 12'd1);
        check("end_heat", {11'd0, heating}, 12'd0);
`ifdef MWAVE_BEEP_EN
        check("beep_on", {11'd0, beep}, 12'd1);
        ticks(2);
        check("beep_2t_state", st(), 12'd4);
        check("beep_2t", {11'd0, beep}, 12'd1);
        ticks(1);
        check("beep_3t_state", st(), 12'd0);
        check("beep_off", {11'd0, beep}, 12'd0);
        check("beep_done_off", {11'd0, done}, 12'd0);
`else
        ticks(10);
        check("done_hold", st(), 12'd4);
        check("done_hold_flag", {11'd0, done}, 12'd1);
        do_stop();
        check("done_stop", st(), 12'd0);
`endif

        // 0:90 counts down from an entered tens digit of 9
        press(4'd9); press(4'd0);
        do_start();
        ticks(1);
        check("tick_089", tm(), 12'h089);

        // stop in RUN pauses; stop in PAUSE clears
        do_stop();
        check("run_stop_pause", st(), 12'd3);
        check("pause_heat", {11'd0, heating}, 12'd0);
        do_stop();
        check("pause_stop_idle", st(), 12'd0);
        check("pause_stop_zero", tm(), 12'h000);

        // door opens on the same cycle as a tick
        press(4'd4); press(4'd5);
        do_start();
        door_closed = 1'b0;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("door_pause", st(), 12'd3);
        check("door_keep", tm(), 12'h045);
        check("door_heat", {11'd0, heating}, 12'd0);
        door_closed = 1'b1;
        cyc();
        check("door_closed_pause", st(), 12'd3);
        do_start();
        check("resume_run", st(), 12'd2);
        ticks(1);
        check("resume_044", tm(), 12'h044);

        // borrow from minutes and from tens
        do_stop(); do_stop();
        press(4'd1); press(4'd0); press(4'd0);
        do_start();
        ticks(1);
        check("borrow_059", tm(), 12'h059);
        do_stop(); do_stop();
        press(4'd1); press(4'd0);
        do_start();
        ticks(1);
        check("borrow_009", tm(), 12'h009);

        // tick on the RUN-entry edge is not counted; keys ignored in RUN
        do_stop(); do_stop();
        press(4'd2); press(4'd0);
        start = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        start = 1'b0;
        tick_1hz = 1'b0;
        check("entry_tick_state", st(), 12'd2);
        check("entry_tick_time", tm(), 12'h020);
        press(4'd7);
        check("run_key_ignored", tm(), 12'h020);

        // shift-out of old minutes, invalid digit, start at zero
        do_stop(); do_stop();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("shift_234", tm(), 12'h234);
        press(4'd12);
        check("bad_key_time", tm(), 12'h234);
        check("bad_key_state", st(), 12'd1);
        do_stop();
        check("entry_stop", tm(), 12'h000);
        do_start();
        check("zero_start", st(), 12'd0);

        // start with the door open is ignored
        press(4'd5);
        door_closed = 1'b0;
        do_start();
        check("open_start", st(), 12'd1);
        door_closed = 1'b1;

        // clear mid-RUN
        do_stop();
        press(4'd3); press(4'd1); press(4'd7);
        do_start();
        check("run_317", tm(), 12'h317);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_state", st(), 12'd0);
        check("clr_time", tm(), 12'h000);
        check("clr_heat", {11'd0, heating}, 12'd0);
        check("clr_done", {11'd0, done}, 12'd0);

        // stop and start together in PAUSE
        press(4'd5);
        do_start();
        do_stop();
        stop = 1'b1;
        start = 1'b1;
        cyc();
        stop = 1'b0;
        start = 1'b0;
        check("pause_both_state", st(), 12'd0);
        check("pause_both_time", tm(), 12'h000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
